// File: rtl/intpol2_pkg.sv
// Shared FSM encoding, core status bit positions and config word offsets
// for the intpol2 job arbiter.
package intpol2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Bit positions inside core_status_i.
  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;

  // The core config bus is CFG_WORDS words of CONFIG_WIDTH bits, word i at [i*W +: W].
  localparam int CFG_WORDS  = 4;
  localparam int CFG_W_MODE = 0;
  localparam int CFG_W_IX   = 1;
  localparam int CFG_W_IX2  = 2;
  localparam int CFG_W_ILEN = 3;

endpackage

// File: rtl/intpol2_rr_arb.sv
// Two-requester round-robin picker: on a tie the requester that was not
// served last wins; a lone request always wins. Purely combinational.
module intpol2_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/intpol2_job_arbiter.sv
// Shares one interpolation core between two requesters: picks a winner,
// loads its config, pulses start, waits for the core's done edge or a watchdog.
module intpol2_job_arbiter
  import intpol2_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int TIMEOUT      = 4096,
  parameter int TO_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        req_i,
  input  logic [CFG_WORDS*CONFIG_WIDTH-1:0] cfg0_i,
  input  logic [CFG_WORDS*CONFIG_WIDTH-1:0] cfg1_i,
  output logic [1:0]                        grant_o,
  output logic [1:0]                        done_o,
  output logic [1:0]                        err_o,
  output logic                              busy_o,
  output logic [CFG_WORDS*CONFIG_WIDTH-1:0] core_config_o,
  output logic                              core_start_o,
  input  logic [7:0]                        core_status_i
);

  // TIMEOUT == 0 turns the watchdog off; the counter then just free-runs in WAIT.
  localparam logic                LP_WDOG_EN   = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] LP_WDOG_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [1:0]                        r_grant;
  logic                              r_last;
  logic                              r_err;
  logic                              r_done_q;
  logic [TO_WIDTH-1:0]               r_wdog;
  logic [CFG_WORDS*CONFIG_WIDTH-1:0] r_config;
  logic [1:0]                        w_rr_grant;
  logic                              w_take;
  logic                              w_done_edge;
  logic                              w_timeout;
  logic                              w_unused_status;

  assign w_unused_status = ^core_status_i[7:STAT_BUSY];

  intpol2_rr_arb u_rr_arb (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_grant (w_rr_grant)
  );

  assign w_take      = (r_state == ST_IDLE) && (req_i != 2'b00);
  assign w_done_edge = core_status_i[STAT_DONE] & ~r_done_q;
  // A done edge in the expiry cycle wins, so the job is not flagged.
  assign w_timeout   = (r_state == ST_WAIT) && LP_WDOG_EN &&
                       (r_wdog == LP_WDOG_LAST) && !w_done_edge;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_take) w_state_nxt = ST_SETUP;
      ST_SETUP:   w_state_nxt = ST_START;
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT:    if (w_done_edge || w_timeout) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the config word is an ordinary register bank, so it is reset along
  // with the control state and the core never sees stale config after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_err    <= 1'b0;
      r_done_q <= 1'b0;
      r_wdog   <= '0;
      r_config <= '0;
    end else begin
      r_err <= w_timeout;

      if (w_take) begin
        r_grant  <= w_rr_grant;
        r_config <= w_rr_grant[1] ? cfg1_i : cfg0_i;
      end else if (r_state == ST_RELEASE) begin
        r_grant <= 2'b00;
        r_last  <= r_grant[1];
      end

      if (r_state == ST_START)     r_wdog <= '0;
      else if (r_state == ST_WAIT) r_wdog <= r_wdog + 1'b1;

      // START re-arms the edge detector with the current level, so a done
      // line already high at start does not count as an edge.
      if (r_state == ST_START || r_state == ST_WAIT) r_done_q <= core_status_i[STAT_DONE];
      else                                           r_done_q <= 1'b0;
    end
  end

  assign grant_o       = r_grant;
  assign core_config_o = r_config;
  assign core_start_o  = (r_state == ST_START);
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = (r_state == ST_RELEASE) ? r_grant : 2'b00;
  assign err_o         = (r_state == ST_RELEASE && r_err) ? r_grant : 2'b00;

endmodule

// File: tb/tb_intpol2_job_arbiter.sv
// Randomized bench for intpol2_job_arbiter: a job-level reference model
// predicts grant/start/done/err timing and config from the arbitration rules.
module tb_intpol2_job_arbiter;
  import intpol2_pkg::*;

  localparam int CW    = 32;
  localparam int TO    = 16;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_i;
  logic [127:0]  cfg0_i, cfg1_i;
  logic [1:0]    grant_o, done_o, err_o;
  logic          busy_o, core_start_o;
  logic [127:0]  core_config_o;
  logic [7:0]    core_status_i;

  intpol2_job_arbiter #(.CONFIG_WIDTH(CW), .TIMEOUT(TO), .TO_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .cfg0_i        (cfg0_i),
    .cfg1_i        (cfg1_i),
    .grant_o       (grant_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .core_config_o (core_config_o),
    .core_start_o  (core_start_o),
    .core_status_i (core_status_i)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: times of the current/last job and the core's behaviour.
  int          last_served, owner;
  int          g_cyc, s_cyc, d_cyc, k_cyc, d0_cyc, stuck_from;
  bit          exp_err, stuck;
  logic [127:0] exp_cfg;
  bit          want [2];
  int          rearm_at [2];
  // Stimulus knobs: plan_d = -1 random, NEVER = core never signals done.
  int          plan_d, plan_stuck;
  bit          auto_req, hold_req;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic core_level(input int c);
    if (k_cyc != NEVER && c >= k_cyc && c < k_cyc + 3) return 1'b1;
    if (stuck && c >= stuck_from && c < d0_cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    req_i         = 2'b00;
    core_status_i = 8'h00;
    want[0] = 1'b0; want[1] = 1'b0;
    rearm_at[0] = 0; rearm_at[1] = 0;
    last_served = 1;
    owner = 0;
    g_cyc = -10; s_cyc = -10; d_cyc = -10;
    k_cyc = NEVER; stuck = 1'b0; d0_cyc = 0; stuck_from = 0;
    exp_err = 1'b0;
    exp_cfg = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    logic [1:0] eg;
    logic       in_job;
    bit         is_stuck;
    int         d, d0off, r;
    @(negedge clk);
    cyc++;
    in_job = (cyc >= g_cyc) && (cyc <= d_cyc);
    eg     = in_job ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("grant", 128'(grant_o), 128'(eg));
    check("busy", 128'(busy_o), 128'(in_job));
    check("start", 128'(core_start_o), 128'(cyc == s_cyc));
    check("done", 128'(done_o), 128'((cyc == d_cyc) ? eg : 2'b00));
    check("err", 128'(err_o), 128'((cyc == d_cyc && exp_err) ? eg : 2'b00));
    check("config", core_config_o, exp_cfg);

    if (cyc == d_cyc) begin
      last_served = owner;
      if (!hold_req) begin
        want[owner]     = 1'b0;
        rearm_at[owner] = cyc + 1 + int'($urandom_range(3));
      end
    end
    if (auto_req) begin
      for (int i = 0; i < 2; i++)
        if (!want[i] && cyc >= rearm_at[i] && $urandom_range(1) == 1) want[i] = 1'b1;
      if (cyc > s_cyc && cyc < d_cyc && want[owner] && $urandom_range(29) == 0) begin
        want[owner]     = 1'b0;
        rearm_at[owner] = NEVER;
      end
      cfg0_i = rand128();
      cfg1_i = rand128();
    end
    req_i         = {want[1], want[0]};
    core_status_i = {7'($urandom), core_level(cyc)};

    // Arbiter is idle after the release cycle; a request now starts a job.
    if (cyc > d_cyc && req_i != 2'b00) begin
      if (req_i == 2'b11) owner = (last_served == 0) ? 1 : 0;
      else                owner = req_i[1] ? 1 : 0;
      g_cyc   = cyc + 1;
      s_cyc   = cyc + 2;
      exp_cfg = (owner == 1) ? cfg1_i : cfg0_i;
      is_stuck = (plan_stuck >= 0) ? (plan_stuck != 0) : ($urandom_range(4) == 0);
      d0off    = 2 + int'($urandom_range(3));
      if (plan_d != -1) d = plan_d;
      else begin
        r = int'($urandom_range(5));
        if (r == 0)      d = NEVER;
        else if (r == 1) d = 15 + int'($urandom_range(1));
        else if (is_stuck) d = d0off + 1 + int'($urandom_range(15 - d0off));
        else             d = 1 + int'($urandom_range(15));
      end
      stuck      = is_stuck;
      stuck_from = g_cyc;
      d0_cyc     = s_cyc + d0off;
      k_cyc      = (d == NEVER) ? NEVER : s_cyc + d;
      if (k_cyc <= s_cyc + TO) begin
        d_cyc = k_cyc + 1; exp_err = 1'b0;
      end else begin
        d_cyc = s_cyc + TO + 1; exp_err = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    cfg0_i = '0; cfg1_i = '0;
    auto_req = 1'b0; hold_req = 1'b0; plan_d = 10; plan_stuck = 0;
    do_reset();

    // Lone request from requester 0, core done 10 cycles after start.
    cfg0_i  = {32'h0000_0040, 32'h0010_0000, 32'h0000_0400, 32'h0000_0001};
    cfg1_i  = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    want[0] = 1'b1;
    run(5);
    check("cfg_ix", 128'(core_config_o[CFG_W_IX*CW +: CW]), 128'(32'h400));
    run(15);

    // Both held from reset: strict alternation starting with requester 0.
    do_reset();
    hold_req = 1'b1; plan_d = 4;
    want[0] = 1'b1; want[1] = 1'b1;
    run(40);
    hold_req = 1'b0;
    do_reset();

    // Core never finishes: watchdog expiry.
    plan_d = NEVER; want[1] = 1'b1;
    run(25);
    // Done already high before start: real edge later, then no edge at all.
    plan_stuck = 1; plan_d = 12; want[0] = 1'b1;
    run(22);
    plan_d = NEVER; want[1] = 1'b1;
    run(25);
    // Done edge exactly in the expiry cycle, and one cycle before it.
    plan_stuck = 0; plan_d = 16; want[0] = 1'b1;
    run(24);
    plan_d = 15; want[1] = 1'b1;
    run(24);

    // Owner drops its request mid-job; the job still completes.
    plan_d = 10; want[0] = 1'b1;
    run(5);
    want[0] = 1'b0;
    run(16);

    // Reset during WAIT: outputs clear at once, no done/err pulse.
    plan_d = NEVER; want[1] = 1'b1;
    run(6);
    #2 rst = 1'b1;
    #1;
    check("rst_grant", 128'(grant_o), 128'(2'b00));
    check("rst_busy", 128'(busy_o), 128'(1'b0));
    check("rst_done", 128'(done_o), 128'(2'b00));
    check("rst_err", 128'(err_o), 128'(2'b00));
    check("rst_start", 128'(core_start_o), 128'(1'b0));
    check("rst_config", core_config_o, 128'(0));
    do_reset();
    plan_d = 3; want[0] = 1'b1; want[1] = 1'b1;
    run(20);

    // Randomized traffic.
    auto_req = 1'b1; plan_d = -1; plan_stuck = -1;
    run(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intpol2_job_arbiter.md
INTPOL2_JOB_ARBITER -- requirements
Module: intpol2_job_arbiter

Interface
REQ-001 Parameter: CONFIG_WIDTH, 32, width of one config_reg word; core config bus is 4*CONFIG_WIDTH.
REQ-002 Parameter: TIMEOUT, 4096, max WAIT cycles before abort; 0 disables watchdog.
REQ-003 Parameter: TO_WIDTH, 16, watchdog counter width; TIMEOUT SHALL fit in TO_WIDTH.
REQ-004 Ports: the block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock, all state on posedge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_i  in  2  job request per requester; held until its done_o pulse.
REQ-008 cfg0_i  in  4*CONFIG_WIDTH  requester 0 core config (bypass/mode, iX, iX2, ilen).
REQ-009 cfg1_i  in  4*CONFIG_WIDTH  requester 1 core config.
REQ-010 grant_o  out  2  one-hot owner of the core; 0 when idle.
REQ-011 done_o  out  2  one-cycle job-complete pulse to owner.
REQ-012 err_o  out  2  one-cycle timeout pulse to owner, coincident with done_o.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 core_config_o  out  4*CONFIG_WIDTH  registered config driven to core.
REQ-015 core_start_o  out  1  one-cycle start pulse to core.
REQ-016 core_status_i  in  8  core status; bit0 done, bit1 busy.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, START, WAIT, RELEASE.
REQ-018 IDLE: if req_i!=0, select winner by round robin, latch its cfg into core_config_o, set grant_o, go SETUP next cycle.
REQ-019 Round robin: with both requests, the requester not served last SHALL win; a single request wins regardless of history.
REQ-020 SETUP: hold config stable one cycle, go START.
REQ-021 START: core_start_o=1 for exactly this cycle, clear watchdog, go WAIT.
REQ-022 WAIT: exit to RELEASE on rising edge of core_status_i[0] (registered previous value, cleared in START); level-high done alone SHALL NOT end WAIT.
REQ-023 WAIT: watchdog increments per cycle; when TIMEOUT!=0 and count reaches TIMEOUT-1 without done edge, go RELEASE flagged as error.
REQ-024 Done edge and timeout in the same cycle: treated as done, no err_o.
REQ-025 RELEASE: done_o[winner]=1 (err_o[winner]=1 if timed out), update last-served pointer, go IDLE; grant_o clears on entry to IDLE.
REQ-026 Latency: req sampled at edge n -> grant_o at n+1, core_start_o at n+2; done edge seen in cycle k -> done_o in k+1, grant_o low in k+2, next grant earliest k+3.
REQ-027 core_config_o SHALL change only on IDLE->SETUP; it holds its value while idle.
REQ-028 Deassertion of the owner's req_i mid-job SHALL NOT abort; job completes and done_o still pulses.
REQ-029 Requests of non-owner are ignored until IDLE; no request is lost if held.

Reset
REQ-030 On rst: state IDLE, grant_o/done_o/err_o/core_start_o/busy_o=0, core_config_o=0, watchdog=0, done-edge register=0.
REQ-031 Last-served pointer resets to requester 1 so requester 0 wins the first tie.
REQ-032 rst mid-job SHALL return to IDLE asynchronously with no done_o/err_o pulse.

Structure
REQ-033 Package intpol2_pkg SHALL hold FSM state encoding, status bit indices (DONE=0, BUSY=1) and config word offsets.
REQ-034 Round-robin selection SHALL be one sub-module, intpol2_rr_arb (2-request, pointer-based, combinational grant).

Verification
REQ-035 Single req_i=01, cfg0_i iX=0x400; core done edge 10 cycles after start -> grant_o=01 at n+1, core_start_o at n+2, core_config_o iX=0x400, done_o=01 one cycle, err_o=00.
REQ-036 req_i=11 from reset, held -> grants 01, 10, 01, 10 alternating; each job starts 3 cycles after previous done_o.
REQ-037 TIMEOUT=16, core never raises done -> err_o and done_o pulse together 16 cycles after WAIT entry; busy_o low next cycle.
REQ-038 core_status_i[0] stuck high before start -> WAIT not exited until a 0->1 transition; timeout if none.
REQ-039 Owner drops req_i during WAIT -> job finishes, done_o pulses; rst asserted in WAIT -> all outputs 0 immediately, no pulse.
REQ-040 Done edge and watchdog expiry same cycle -> done_o=1, err_o=0.
